// File: rtl/int_source_conditioner.sv
// int_source_conditioner
//   Front end of the interrupt controller. Synchronises the raw peripheral IRQ
//   lines and applies per-source polarity and edge/level mode. Holds the
//   software-visible INT_EN, INT_MODE, INT_FLAG and INT_RAW registers and drives
//   the controller's int_sources, ea and en1..en3 inputs.
//
//   Optional feature macro: INT_SRC_GLITCH_FILTER_EN
//     defined   - a per-source stability counter (FILTER_LEN cycles) sits between
//                 the polarity-corrected level and the edge/level logic.
//     undefined - no counters; the polarity-corrected level is used directly.

module int_source_conditioner #(
   parameter int NUM_SRC     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] irq_raw,
   input  logic [1:0]         bus_addr,
   input  logic               bus_wr,
   input  logic               bus_rd,
   input  logic [7:0]         bus_wdata,
   output logic [7:0]         bus_rdata,
   output logic [NUM_SRC-1:0] int_sources,
   output logic               ea,
   output logic               en1,
   output logic               en2,
   output logic               en3
);

   // Register map selected by bus_addr.
   typedef enum logic [1:0] {
      REG_EN   = 2'd0,
      REG_MODE = 2'd1,
      REG_FLAG = 2'd2,
      REG_RAW  = 2'd3
   } reg_addr_t;

   // Parameter sanity: the controller interface is fixed at four sources and
   // the synchroniser depth is only characterised for 2..4 stages.
   if (NUM_SRC != 4 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1) begin : g_param_check
      $error("int_source_conditioner: unsupported parameter combination");
   end

   // ------------------------------------------------------------------------
   // Software registers
   // ------------------------------------------------------------------------
   logic               ea_q;
   logic [3:1]         en_q;
   logic [NUM_SRC-1:0] mode_q;   // 1 = edge, 0 = level
   logic [NUM_SRC-1:0] pol_q;    // 1 = active-low / falling edge
   logic [NUM_SRC-1:0] flag_q;

   reg_addr_t addr;
   logic      wr_en_reg;
   logic      wr_mode_reg;
   logic      wr_flag_reg;

   assign addr        = reg_addr_t'(bus_addr);
   assign wr_en_reg   = bus_wr && (addr == REG_EN);
   assign wr_mode_reg = bus_wr && (addr == REG_MODE);
   assign wr_flag_reg = bus_wr && (addr == REG_FLAG);

   // ------------------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------------------
   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] sync_lvl;
   logic [NUM_SRC-1:0] s;

   // Shift each raw line through SYNC_STAGES flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the synchroniser is an array of flops, not a RAM, so every
         // element is cleared by the asynchronous reset; a reset mid-event must
         // leave nothing in flight.
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let each stage sample the previous
         // stage's old value, which is what makes this a shift register.
         sync_q[0] <= irq_raw;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign s        = sync_lvl ^ pol_q;

   // ------------------------------------------------------------------------
   // Optional glitch filter
   // ------------------------------------------------------------------------
   logic [NUM_SRC-1:0] lvl;      // level seen by the edge/level logic

`ifdef INT_SRC_GLITCH_FILTER_EN
   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [CNT_W-1:0]   filt_cnt [NUM_SRC];
   logic [NUM_SRC-1:0] filt_q;

   // Accept a new level only after s has differed from the filtered level for
   // FILTER_LEN consecutive cycles; any return to the old level restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            filt_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (s[i] == filt_q[i]) begin
               filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
               filt_q[i]   <= s[i];
               filt_cnt[i] <= '0;
            end else begin
               filt_cnt[i] <= filt_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = s;
`endif

   // ------------------------------------------------------------------------
   // Edge detection and flags
   // ------------------------------------------------------------------------
   logic [NUM_SRC-1:0] lvl_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] mode_nxt;
   logic [NUM_SRC-1:0] flag_clr;
   logic [NUM_SRC-1:0] flag_nxt;

   assign rise = lvl & ~lvl_d;

   // Next flag value: W1C clears, a rise sets (set wins), and a source that is
   // in level mode after this edge holds no flag.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned and no latch is inferred.
      mode_nxt = mode_q;
      flag_clr = '0;
      if (wr_mode_reg) begin
         mode_nxt = bus_wdata[NUM_SRC-1:0];
      end
      if (wr_flag_reg) begin
         flag_clr = bus_wdata[NUM_SRC-1:0];
      end
      flag_nxt = ((flag_q & ~flag_clr) | rise) & mode_nxt;
   end

   // Delayed level for edge detection, the flags, and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_d       <= '0;
         flag_q      <= '0;
         int_sources <= '0;
      end else begin
         lvl_d       <= lvl;
         flag_q      <= flag_nxt;
         int_sources <= (mode_q & flag_q) | (~mode_q & lvl_d);
      end
   end

   // ------------------------------------------------------------------------
   // Enable and mode registers
   // ------------------------------------------------------------------------

   // Bus writes to INT_EN and INT_MODE; unimplemented INT_EN bits are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ea_q   <= 1'b0;
         en_q   <= '0;
         mode_q <= '0;
         pol_q  <= '0;
      end else begin
         if (wr_en_reg) begin
            ea_q <= bus_wdata[7];
            en_q <= bus_wdata[3:1];
         end
         if (wr_mode_reg) begin
            mode_q <= bus_wdata[3:0];
            pol_q  <= bus_wdata[7:4];
         end
      end
   end

   assign ea  = ea_q;
   assign en1 = en_q[1];
   assign en2 = en_q[2];
   assign en3 = en_q[3];

   // ------------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------------
   logic [7:0] rd_mux;

   // Select the register image addressed by the current read.
   always_comb begin
      rd_mux = '0;
      unique case (addr)
         REG_EN:   rd_mux = {ea_q, 3'b000, en_q, 1'b0};
         REG_MODE: rd_mux = {pol_q, mode_q};
         REG_FLAG: rd_mux = {4'b0000, flag_q};
         REG_RAW:  rd_mux = {4'b0000, s};
         default:  rd_mux = '0;
      endcase
   end

   // Register read data; a simultaneous write returns the pre-write image
   // because the mux sees register values from before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_rdata <= '0;
      end else if (bus_rd) begin
         bus_rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_int_source_conditioner.sv
// Directed testbench for int_source_conditioner. Inputs are driven and
// outputs sampled 1 ns after each rising clock edge.

module tb_int_source_conditioner;

   localparam int NUM_SRC     = 4;
   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 4;
`ifdef INT_SRC_GLITCH_FILTER_EN
   localparam int LAT = SYNC_STAGES + FILTER_LEN + 2;
`else
   localparam int LAT = SYNC_STAGES + 2;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NUM_SRC-1:0] irq_raw;
   logic [1:0]         bus_addr;
   logic               bus_wr;
   logic               bus_rd;
   logic [7:0]         bus_wdata;
   logic [7:0]         bus_rdata;
   logic [NUM_SRC-1:0] int_sources;
   logic               ea, en1, en2, en3;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] rd;

   int_source_conditioner #(
      .NUM_SRC    (NUM_SRC),
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_raw    (irq_raw),
      .bus_addr   (bus_addr),
      .bus_wr     (bus_wr),
      .bus_rd     (bus_rd),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .int_sources(int_sources),
      .ea         (ea),
      .en1        (en1),
      .en2        (en2),
      .en3        (en3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_wr    = 1'b1;
      step();
      bus_wr    = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      bus_addr = a;
      bus_rd   = 1'b1;
      step();
      bus_rd   = 1'b0;
      d        = bus_rdata;
   endtask

   initial begin
      rst_n     = 1'b0;
      irq_raw   = '0;
      bus_addr  = '0;
      bus_wr    = 1'b0;
      bus_rd    = 1'b0;
      bus_wdata = '0;
      step(3);
      check("rst_int_sources", 32'(int_sources), 32'h0);
      check("rst_enables", 32'({ea, en3, en2, en1}), 32'h0);
      check("rst_rdata", 32'(bus_rdata), 32'h0);
      rst_n = 1'b1;
      step(2);

      // T1: enables and INT_EN read-back, unimplemented bits ignored
      bus_write(2'd0, 8'h8E);
      check("t1_enables", 32'({ea, en3, en2, en1}), 32'hF);
      bus_read(2'd0, rd);
      check("t1_read_en", 32'(rd), 32'h8E);
      bus_write(2'd0, 8'h71);
      bus_read(2'd0, rd);
      check("t1_read_en_masked", 32'(rd), 32'h00);
      bus_write(2'd0, 8'h8E);

      // T2: edge mode on source 0, single-cycle pulse, then W1C
      bus_write(2'd1, 8'h01);
      irq_raw[0] = 1'b1;
      step();
      irq_raw[0] = 1'b0;
      step(LAT - 2);
      check("t2_before_latency", 32'(int_sources[0]), 32'h0);
      step();
      check("t2_at_latency", 32'(int_sources[0]), 32'h1);
      step(5);
      check("t2_sticky", 32'(int_sources[0]), 32'h1);
      bus_read(2'd2, rd);
      check("t2_read_flag", 32'(rd), 32'h01);
      bus_write(2'd2, 8'h01);
      check("t2_w1c_same_edge", 32'(int_sources[0]), 32'h1);
      step();
      check("t2_w1c_next", 32'(int_sources[0]), 32'h0);
      bus_read(2'd2, rd);
      check("t2_flag_cleared", 32'(rd), 32'h00);

      // T3: level mode, active-low on source 2
      irq_raw[2] = 1'b1;
      step(LAT + 2);
      bus_write(2'd1, 8'h40);
      step(LAT);
      check("t3_idle_high", 32'(int_sources[2]), 32'h0);
      irq_raw[2] = 1'b0;
      step(LAT - 1);
      check("t3_assert_before", 32'(int_sources[2]), 32'h0);
      step();
      check("t3_assert", 32'(int_sources[2]), 32'h1);
      bus_read(2'd3, rd);
      check("t3_read_raw", 32'(rd), 32'h04);
      irq_raw[2] = 1'b1;
      step(LAT - 1);
      check("t3_deassert_before", 32'(int_sources[2]), 32'h1);
      step();
      check("t3_deassert", 32'(int_sources[2]), 32'h0);
      irq_raw[2] = 1'b0;
      bus_write(2'd1, 8'h00);
      step(LAT + 2);

      // T4: rise on source 1 coincides with W1C of bit 1 -> set wins
      bus_write(2'd1, 8'h02);
      irq_raw[1] = 1'b1;
      step(LAT - 2);
      bus_write(2'd2, 8'h02);
      bus_read(2'd2, rd);
      check("t4_set_wins", 32'(rd), 32'h02);
      step(2);
      check("t4_int_src", 32'(int_sources[1]), 32'h1);
      bus_write(2'd2, 8'h02);
      bus_read(2'd2, rd);
      check("t4_w1c_alone", 32'(rd), 32'h00);
      irq_raw[1] = 1'b0;
      step(LAT + 2);
      irq_raw[1] = 1'b1;
      step(LAT + 2);
      bus_read(2'd2, rd);
      check("t4_reflag", 32'(rd), 32'h02);
      bus_write(2'd1, 8'h00);
      bus_read(2'd2, rd);
      check("t4_mode_to_level_clears", 32'(rd), 32'h00);
      irq_raw[1] = 1'b0;
      step(LAT + 2);

      // Flags latch while disabled; enables do not gate them
      bus_write(2'd0, 8'h00);
      bus_write(2'd1, 8'h08);
      irq_raw[3] = 1'b1;
      step();
      irq_raw[3] = 1'b0;
      step(LAT + 2);
      check("dis_int_src3", 32'(int_sources), 32'h8);
      check("dis_enables", 32'({ea, en3, en2, en1}), 32'h0);

      // Simultaneous read and write returns the pre-write value
      bus_addr  = 2'd0;
      bus_wdata = 8'h8E;
      bus_wr    = 1'b1;
      bus_rd    = 1'b1;
      step();
      bus_wr    = 1'b0;
      bus_rd    = 1'b0;
      check("rdwr_old_value", 32'(bus_rdata), 32'h00);
      bus_read(2'd0, rd);
      check("rdwr_new_value", 32'(rd), 32'h8E);

      // T5: reset with flag[3]=1 and a 3-cycle pulse mid-synchroniser
      irq_raw[3] = 1'b1;
      step(2);
      rst_n = 1'b0;
      #1;
      check("t5_int_src_now", 32'(int_sources), 32'h0);
      check("t5_enables_now", 32'({ea, en3, en2, en1}), 32'h0);
      check("t5_rdata_now", 32'(bus_rdata), 32'h0);
      step();
      irq_raw[3] = 1'b0;
      step();
      rst_n = 1'b1;
      step(LAT + 4);
      check("t5_no_flag_out", 32'(int_sources), 32'h0);
      bus_read(2'd2, rd);
      check("t5_no_flag_reg", 32'(rd), 32'h00);

`ifdef INT_SRC_GLITCH_FILTER_EN
      // T6: 3-cycle pulse filtered out, 5-cycle pulse accepted at cycle 8
      bus_write(2'd1, 8'h01);
      irq_raw[0] = 1'b1;
      step(FILTER_LEN - 1);
      irq_raw[0] = 1'b0;
      step(LAT + 4);
      bus_read(2'd2, rd);
      check("t6_short_ignored", 32'(rd), 32'h00);
      irq_raw[0] = 1'b1;
      step(FILTER_LEN + 1);
      irq_raw[0] = 1'b0;
      step(LAT - FILTER_LEN - 2);
      check("t6_before", 32'(int_sources[0]), 32'h0);
      step();
      check("t6_at_8", 32'(int_sources[0]), 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
